// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: divided clock plus registered edge strobes,
// glitch-free divisor changes at period boundaries, selectable stop behaviour.
module clock_divider_prog #(
   parameter int WIDTH        = 16,
   parameter int DEFAULT_DVSR = 4,
   parameter int STOP_MODE    = 0
) (
   input  logic             i_CLK,
   input  logic             i_RST,
   input  logic             i_EN,
   input  logic [WIDTH-1:0] i_DVSR,
   input  logic             i_LOAD,
   output logic             o_CLK_DIV,
   output logic             o_RISE,
   output logic             o_FALL,
   output logic             o_LOAD_ACK,
   output logic             o_BUSY
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state, nxt_state;
   logic [WIDTH-1:0] pos, nxt_pos;
   logic [WIDTH-1:0] dvsr, nxt_dvsr;
   logic [WIDTH-1:0] pend, nxt_pend;
   logic             pend_vld, nxt_pend_vld;
   logic             nxt_ack;
   logic             nxt_clk;
   logic [WIDTH-1:0] dvsr_req;
   logic             at_end;
   logic             stop;
   logic             close;

   assign dvsr_req = (i_DVSR < WIDTH'(2)) ? WIDTH'(2) : i_DVSR;
   assign at_end   = (pos == dvsr - WIDTH'(1));

   // The edge that ends a period immediately (or terminates a drain) also closes it,
   // so a queued divisor is committed there instead of lingering into IDLE.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      nxt_state    = state;
      nxt_pos      = pos;
      nxt_dvsr     = dvsr;
      nxt_pend     = pend;
      nxt_pend_vld = pend_vld;
      nxt_ack      = 1'b0;
      stop         = 1'b0;
      close        = 1'b0;

      case (state)
         IDLE: begin
            nxt_pos = '0;
            if (i_LOAD) begin
               nxt_dvsr = dvsr_req;
               nxt_ack  = 1'b1;
            end
            if (i_EN) nxt_state = RUN;
         end
         default: begin
            stop  = (STOP_MODE == 0) ? !i_EN : (at_end && !i_EN);
            close = at_end || stop;

            if (close && i_LOAD) begin
               nxt_dvsr     = dvsr_req;
               nxt_pend_vld = 1'b0;
               nxt_ack      = 1'b1;
            end else if (close && pend_vld) begin
               nxt_dvsr     = pend;
               nxt_pend_vld = 1'b0;
               nxt_ack      = 1'b1;
            end else if (i_LOAD) begin
               nxt_pend     = dvsr_req;
               nxt_pend_vld = 1'b1;
            end

            if (stop) begin
               nxt_state = IDLE;
               nxt_pos   = '0;
            end else begin
               nxt_state = i_EN ? RUN : DRAIN;
               nxt_pos   = at_end ? '0 : pos + WIDTH'(1);
            end
         end
      endcase

      // Low for positions 0..L-1, high for L..D-1, so odd D gets the longer high phase.
      nxt_clk = (nxt_state != IDLE) && (nxt_pos >= (nxt_dvsr >> 1));
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state      <= IDLE;
         pos        <= '0;
         dvsr       <= WIDTH'(DEFAULT_DVSR);
         pend       <= '0;
         pend_vld   <= 1'b0;
         o_CLK_DIV  <= 1'b0;
         o_RISE     <= 1'b0;
         o_FALL     <= 1'b0;
         o_LOAD_ACK <= 1'b0;
         o_BUSY     <= 1'b0;
      end else begin
         state      <= nxt_state;
         pos        <= nxt_pos;
         dvsr       <= nxt_dvsr;
         pend       <= nxt_pend;
         pend_vld   <= nxt_pend_vld;
         o_CLK_DIV  <= nxt_clk;
         o_RISE     <= nxt_clk && !o_CLK_DIV;
         o_FALL     <= !nxt_clk && o_CLK_DIV;
         o_LOAD_ACK <= nxt_ack;
         o_BUSY     <= (nxt_state != IDLE);
      end
   end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: both stop modes side by side, directed literal
// sequences followed by randomized traffic against a period-level reference model.
module tb_clock_divider_prog;

   localparam int WIDTH = 16;
   localparam int DEF   = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en  = 1'b0;
   logic             ld  = 1'b0;
   logic [WIDTH-1:0] dv  = '0;

   logic clk_div [2];
   logic rise    [2];
   logic fall    [2];
   logic ack     [2];
   logic busy    [2];

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   clock_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DVSR(DEF), .STOP_MODE(0)) u_dut0 (
      .i_CLK(clk), .i_RST(rst), .i_EN(en), .i_DVSR(dv), .i_LOAD(ld),
      .o_CLK_DIV(clk_div[0]), .o_RISE(rise[0]), .o_FALL(fall[0]),
      .o_LOAD_ACK(ack[0]), .o_BUSY(busy[0])
   );

   clock_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DVSR(DEF), .STOP_MODE(1)) u_dut1 (
      .i_CLK(clk), .i_RST(rst), .i_EN(en), .i_DVSR(dv), .i_LOAD(ld),
      .o_CLK_DIV(clk_div[1]), .o_RISE(rise[1]), .o_FALL(fall[1]),
      .o_LOAD_ACK(ack[1]), .o_BUSY(busy[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   // Reference model: tracks cycles into the current period (t) and the divisor
   // in force; output level is simply t >= D/2 while running.
   bit m_on [2];
   int m_t  [2];
   int m_d  [2];
   int m_pd [2];
   bit m_pv [2];
   bit e_clk[2], e_rise[2], e_fall[2], e_ack[2], e_busy[2];

   function automatic int clamp(input int x);
      return (x < 2) ? 2 : x;
   endfunction

   task automatic model_step(input int m);
      bit prev, stop, last, closes;
      prev = e_clk[m];
      if (rst) begin
         m_on[m] = 0; m_t[m] = 0; m_d[m] = DEF; m_pv[m] = 0;
         e_clk[m] = 0; e_rise[m] = 0; e_fall[m] = 0; e_ack[m] = 0; e_busy[m] = 0;
         return;
      end
      e_ack[m] = 0;
      if (!m_on[m]) begin
         if (ld) begin m_d[m] = clamp(int'(dv)); e_ack[m] = 1; end
         if (en) begin m_on[m] = 1; m_t[m] = 0; end
      end else begin
         last   = (m_t[m] == m_d[m] - 1);
         stop   = (m == 0) ? !en : (last && !en);
         closes = last || stop;
         if (closes && ld) begin
            m_d[m] = clamp(int'(dv)); m_pv[m] = 0; e_ack[m] = 1;
         end else if (closes && m_pv[m]) begin
            m_d[m] = m_pd[m]; m_pv[m] = 0; e_ack[m] = 1;
         end else if (ld) begin
            m_pd[m] = clamp(int'(dv)); m_pv[m] = 1;
         end
         if (stop) begin m_on[m] = 0; m_t[m] = 0; end
         else m_t[m] = last ? 0 : m_t[m] + 1;
      end
      e_clk[m]  = m_on[m] && (m_t[m] >= m_d[m] / 2);
      e_rise[m] = e_clk[m] && !prev;
      e_fall[m] = !e_clk[m] && prev;
      e_busy[m] = m_on[m];
   endtask

   always begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      if (chk_en) begin
         for (int m = 0; m < 2; m++)
            check($sformatf("model_cmp dut%0d {clk,rise,fall,ack,busy}", m),
                  {27'd0, clk_div[m], rise[m], fall[m], ack[m], busy[m]},
                  {27'd0, e_clk[m], e_rise[m], e_fall[m], e_ack[m], e_busy[m]});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] s_clk [2];
      logic [15:0] s_rise[2];
      logic [15:0] s_fall[2];
      logic [15:0] s_ack [2];
      logic [15:0] s_busy[2];

      // Reset state
      chk_en = 1'b1;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int m = 0; m < 2; m++)
         check($sformatf("reset_outputs dut%0d", m),
               {clk_div[m], rise[m], fall[m], ack[m], busy[m]}, 5'b00000);

      // Default D=4 after enable: 0,0,1,1 repeating, rise at 3,7, fall at 5
      en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cyc();
         s_clk[0][k] = clk_div[0]; s_rise[0][k] = rise[0];
         s_fall[0][k] = fall[0];   s_busy[0][k] = busy[0];
      end
      check("d4_clk_seq",  32'(s_clk[0][7:0]),  32'b11001100);
      check("d4_rise_seq", 32'(s_rise[0][7:0]), 32'b01000100);
      check("d4_fall_seq", 32'(s_fall[0][7:0]), 32'b00010000);
      check("d4_busy_seq", 32'(s_busy[0][7:0]), 32'b11111111);

      // Load 5 mid-period: old period completes, then 0,0,1,1,1
      cyc();
      ld = 1'b1; dv = 16'd5;
      cyc();
      ld = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         s_clk[0][k] = clk_div[0]; s_ack[0][k] = ack[0];
      end
      check("load5_clk_seq", 32'(s_clk[0][9:0]), 32'b1001110011);
      check("load5_ack_seq", 32'(s_ack[0][9:0]), 32'b0000000100);

      // Drop enable in the high phase: immediate stop vs. drain to boundary
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         for (int m = 0; m < 2; m++) begin
            s_clk[m][k] = clk_div[m]; s_fall[m][k] = fall[m]; s_busy[m][k] = busy[m];
         end
      end
      check("stop0_clk",  32'(s_clk[0][2:0]),  32'b000);
      check("stop0_fall", 32'(s_fall[0][2:0]), 32'b001);
      check("stop0_busy", 32'(s_busy[0][2:0]), 32'b000);
      check("stop1_clk",  32'(s_clk[1][2:0]),  32'b011);
      check("stop1_fall", 32'(s_fall[1][2:0]), 32'b100);
      check("stop1_busy", 32'(s_busy[1][2:0]), 32'b011);

      // Divisor 0 loaded in IDLE clamps to 2
      ld = 1'b1; dv = 16'd0;
      cyc();
      ld = 1'b0;
      check("idle_load_ack", 32'(ack[0]), 32'd1);
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         s_clk[0][k] = clk_div[0]; s_rise[0][k] = rise[0]; s_fall[0][k] = fall[0];
      end
      check("d2_clk_seq",  32'(s_clk[0][3:0]),  32'b1010);
      check("d2_rise_seq", 32'(s_rise[0][3:0]), 32'b1010);
      check("d2_fall_seq", 32'(s_fall[0][3:0]), 32'b0100);

      // Drain mode, D=6, enable dropped at position 1
      en = 1'b0;
      repeat (3) cyc();
      ld = 1'b1; dv = 16'd6;
      cyc();
      ld = 1'b0; en = 1'b1;
      cyc();
      cyc();
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         s_clk[1][k] = clk_div[1]; s_fall[1][k] = fall[1]; s_busy[1][k] = busy[1];
      end
      check("drain_clk_seq",  32'(s_clk[1][4:0]),  32'b01110);
      check("drain_fall_seq", 32'(s_fall[1][4:0]), 32'b10000);
      check("drain_busy_seq", 32'(s_busy[1][4:0]), 32'b01111);

      // Re-assert enable during drain at position 3: unbroken period
      en = 1'b1;
      cyc();
      cyc();
      en = 1'b0;
      cyc();
      cyc();
      en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         s_clk[1][k] = clk_div[1]; s_fall[1][k] = fall[1]; s_busy[1][k] = busy[1];
      end
      check("resume_clk_seq",  32'(s_clk[1][5:0]),  32'b100011);
      check("resume_fall_seq", 32'(s_fall[1][5:0]), 32'b000100);
      check("resume_busy_seq", 32'(s_busy[1][5:0]), 32'b111111);

      // Reset mid-period with a pending load: pending divisor discarded
      ld = 1'b1; dv = 16'd9;
      cyc();
      ld = 1'b0; rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int m = 0; m < 2; m++)
         check($sformatf("midrun_reset_outputs dut%0d", m),
               {clk_div[m], rise[m], fall[m], ack[m], busy[m]}, 5'b00000);
      for (int k = 0; k < 8; k++) begin
         cyc();
         for (int m = 0; m < 2; m++) begin
            s_clk[m][k] = clk_div[m]; s_ack[m][k] = ack[m];
         end
      end
      for (int m = 0; m < 2; m++) begin
         check($sformatf("post_reset_clk dut%0d", m), 32'(s_clk[m][7:0]), 32'b11001100);
         check($sformatf("post_reset_ack dut%0d", m), 32'(s_ack[m][7:0]), 32'd0);
      end

      // Randomized traffic, checked every cycle by the model comparison
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) en = ~en;
         ld  = ($urandom_range(0, 9) == 0);
         dv  = WIDTH'($urandom_range(0, 9));
         rst = ($urandom_range(0, 299) == 0);
         cyc();
      end
      rst = 1'b0; ld = 1'b0;
      cyc();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
